// File: rtl/rgb_led_seq.sv
// Pattern sequencer for one rgb_led PWM driver: turns OFF/SOLID/BLINK/FADE
// commands into r/g/b values plus a one-cycle set strobe.
module rgb_led_seq #(
  parameter int CLK_DIV = 50000,
  parameter int COLOR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_mode,
  input  logic [COLOR_W-1:0] cmd_r,
  input  logic [COLOR_W-1:0] cmd_g,
  input  logic [COLOR_W-1:0] cmd_b,
  input  logic [7:0]         cmd_period,
  output logic               busy,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               set
);

  localparam int PRE_W = $clog2(CLK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_SOLID = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_FADE  = 2'b11;

  typedef enum logic [2:0] {
    S_INIT,
    S_LOAD,
    S_HOLD,
    S_BLINK_ON,
    S_BLINK_OFF,
    S_FADE_UP,
    S_FADE_DOWN
  } state_t;

  // Channel index 2 is red, 1 is green, 0 is blue.
  typedef logic [2:0][COLOR_W-1:0] rgb_t;

  state_t           state, state_n;
  logic [PRE_W-1:0] pre;
  logic             tick;
  logic [7:0]       cnt, cnt_n, cnt_inc;
  logic [7:0]       period_q, period_n;
  logic [1:0]       mode_q, mode_n;
  rgb_t             target_q, target_n;
  rgb_t             col_q, col_n;
  rgb_t             col_up, col_down;
  logic             pulse_q, pulse_n;
  logic             accept, step;

  always_ff @(posedge clk) begin
    if (rst || tick) pre <= '0;
    else             pre <= pre + PRE_W'(1);
  end

  assign tick      = (pre == PRE_LAST);
  assign cmd_ready = (state != S_INIT) && (state != S_LOAD);
  assign accept    = cmd_valid && cmd_ready;
  assign cnt_inc   = cnt + 8'd1;
  assign step      = tick && (cnt_inc == period_q);

  // Per-channel saturating fade steps; channels never wrap.
  always_comb begin
    col_up   = col_q;
    col_down = col_q;
    for (int i = 0; i < 3; i++) begin
      col_up[i]   = (col_q[i] < target_q[i]) ? col_q[i] + COLOR_W'(1) : col_q[i];
      col_down[i] = (col_q[i] != '0) ? col_q[i] - COLOR_W'(1) : col_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      cnt      <= '0;
      period_q <= 8'd1;
      mode_q   <= MODE_OFF;
      target_q <= '0;
      col_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      period_q <= period_n;
      mode_q   <= mode_n;
      target_q <= target_n;
      col_q    <= col_n;
      pulse_q  <= pulse_n;
    end
  end

  // An accepted command always wins, so a coincident tick is simply dropped.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    period_n = period_q;
    mode_n   = mode_q;
    target_n = target_q;
    col_n    = col_q;
    pulse_n  = 1'b0;

    if (accept) begin
      state_n  = S_LOAD;
      cnt_n    = '0;
      mode_n   = cmd_mode;
      target_n = {cmd_r, cmd_g, cmd_b};
      period_n = (cmd_period == 8'd0) ? 8'd1 : cmd_period;
      case (cmd_mode)
        MODE_SOLID, MODE_BLINK: col_n = {cmd_r, cmd_g, cmd_b};
        default:                col_n = '0;
      endcase
    end else begin
      case (state)
        S_INIT: state_n = S_HOLD;
        S_LOAD: begin
          cnt_n = '0;
          case (mode_q)
            MODE_BLINK: state_n = S_BLINK_ON;
            MODE_FADE:  state_n = S_FADE_UP;
            default:    state_n = S_HOLD;
          endcase
        end
        S_BLINK_ON, S_BLINK_OFF: begin
          if (step) begin
            cnt_n   = '0;
            pulse_n = 1'b1;
            if (state == S_BLINK_ON) begin
              state_n = S_BLINK_OFF;
              col_n   = '0;
            end else begin
              state_n = S_BLINK_ON;
              col_n   = target_q;
            end
          end else if (tick) begin
            cnt_n = cnt_inc;
          end
        end
        S_FADE_UP: begin
          if (step) begin
            cnt_n   = '0;
            pulse_n = 1'b1;
            col_n   = col_up;
            if (col_up == target_q) state_n = S_FADE_DOWN;
          end else if (tick) begin
            cnt_n = cnt_inc;
          end
        end
        S_FADE_DOWN: begin
          if (step) begin
            cnt_n   = '0;
            pulse_n = 1'b1;
            col_n   = col_down;
            if (col_down == '0) state_n = S_FADE_UP;
          end else if (tick) begin
            cnt_n = cnt_inc;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  assign busy = (state == S_BLINK_ON) || (state == S_BLINK_OFF) ||
                (state == S_FADE_UP)  || (state == S_FADE_DOWN) ||
                ((state == S_LOAD) && mode_q[1]);

  // Gated by rst so reset kills any strobe immediately, including the INIT one.
  assign set = !rst && ((state == S_INIT) || (state == S_LOAD) || pulse_q);

  assign r = col_q[2];
  assign g = col_q[1];
  assign b = col_q[0];

endmodule

// File: tb/tb_rgb_led_seq.sv
// Directed bench for rgb_led_seq: dut_a (CLK_DIV=4) covers reset/solid/blink/
// preempt/off, dut_b (CLK_DIV=2) covers fade and reset in the middle of a fade.
module tb_rgb_led_seq;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         a_valid, a_ready, a_busy, a_set;
  logic [1:0]   a_mode;
  logic [W-1:0] a_cr, a_cg, a_cb, a_r, a_g, a_b;
  logic [7:0]   a_period;
  logic         b_valid, b_ready, b_busy, b_set;
  logic [1:0]   b_mode;
  logic [W-1:0] b_cr, b_cg, b_cb, b_r, b_g, b_b;
  logic [7:0]   b_period;

  logic [3*W-1:0] a_rgb, b_rgb;
  assign a_rgb = {a_r, a_g, a_b};
  assign b_rgb = {b_r, b_g, b_b};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  // Cycles since reset release; the INIT cycle is cycle 0.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  rgb_led_seq #(.CLK_DIV(4), .COLOR_W(W)) dut_a (
    .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_mode(a_mode), .cmd_r(a_cr), .cmd_g(a_cg), .cmd_b(a_cb),
    .cmd_period(a_period), .busy(a_busy), .r(a_r), .g(a_g), .b(a_b), .set(a_set)
  );

  rgb_led_seq #(.CLK_DIV(2), .COLOR_W(W)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_mode(b_mode), .cmd_r(b_cr), .cmd_g(b_cg), .cmd_b(b_cb),
    .cmd_period(b_period), .busy(b_busy), .r(b_r), .g(b_g), .b(b_b), .set(b_set)
  );

  function automatic logic [3*W-1:0] rgb(input int rr, input int gg, input int bb);
    rgb = {W'(rr), W'(gg), W'(bb)};
  endfunction

  // Hand-computed FADE (3,1,0) staircase, one entry per step.
  function automatic logic [3*W-1:0] fade_level(input int s);
    case (s)
      0: fade_level = rgb(0, 0, 0);
      1: fade_level = rgb(1, 1, 0);
      2: fade_level = rgb(2, 1, 0);
      3: fade_level = rgb(3, 1, 0);
      4: fade_level = rgb(2, 0, 0);
      5: fade_level = rgb(1, 0, 0);
      6: fade_level = rgb(0, 0, 0);
      7: fade_level = rgb(1, 1, 0);
      default: fade_level = rgb(2, 1, 0);
    endcase
  endfunction

  task automatic wait_phase(input int div, input int ph);
    for (int i = 0; i < div && (cyc % div) != ph; i++) @(negedge clk);
  endtask

  task automatic send_a(input logic [1:0] m, input int rr, input int gg, input int bb, input int p);
    a_mode = m; a_cr = W'(rr); a_cg = W'(gg); a_cb = W'(bb); a_period = 8'(p);
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [1:0] m, input int rr, input int gg, input int bb, input int p);
    b_mode = m; b_cr = W'(rr); b_cg = W'(gg); b_cb = W'(bb); b_period = 8'(p);
    b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (a_rgb !== '0) begin errors++; $display("[TB] FAIL reset_rgb_a: got %h expected 0", a_rgb); end
    checks++; if ({a_set, a_ready, a_busy} !== 3'b000) begin errors++; $display("[TB] FAIL reset_ctl_a: set/ready/busy got %b expected 000", {a_set, a_ready, a_busy}); end
    checks++; if ({b_rgb, b_set, b_ready} !== '0) begin errors++; $display("[TB] FAIL reset_b: got %h expected 0", {b_rgb, b_set, b_ready}); end
    rst = 1'b0;
    #1;
    checks++; if ({a_set, a_ready} !== 2'b10) begin errors++; $display("[TB] FAIL init_strobe_a: set/ready got %b expected 10", {a_set, a_ready}); end
    checks++; if (a_rgb !== '0) begin errors++; $display("[TB] FAIL init_rgb_a: got %h expected 0", a_rgb); end
    checks++; if (b_set !== 1'b1) begin errors++; $display("[TB] FAIL init_strobe_b: got %b expected 1", b_set); end
    @(negedge clk);
    checks++; if ({a_set, a_ready} !== 2'b01) begin errors++; $display("[TB] FAIL hold_ready_a: set/ready got %b expected 01", {a_set, a_ready}); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_ready_b: got %b expected 1", b_ready); end
  endtask

  task automatic test_solid;
    int pulses, changed;
    logic [3*W-1:0] exp_c;
    exp_c = rgb(31, 0, 10);
    send_a(2'b01, 31, 0, 10, 0);
    checks++; if (a_rgb !== exp_c) begin errors++; $display("[TB] FAIL solid_rgb: got %h expected %h", a_rgb, exp_c); end
    checks++; if ({a_set, a_ready, a_busy} !== 3'b100) begin errors++; $display("[TB] FAIL solid_load: set/ready/busy got %b expected 100", {a_set, a_ready, a_busy}); end
    pulses = 0; changed = 0;
    repeat (1000) begin
      @(negedge clk);
      if (a_set) pulses++;
      if (a_rgb !== exp_c || a_busy !== 1'b0) changed++;
    end
    checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL solid_no_set: got %0d pulses expected 0", pulses); end
    checks++; if (changed != 0) begin errors++; $display("[TB] FAIL solid_static: got %0d bad cycles expected 0", changed); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("[TB] FAIL solid_ready: got %b expected 1", a_ready); end
  endtask

  task automatic test_blink;
    logic [3*W-1:0] exp_c;
    wait_phase(4, 3);
    send_a(2'b10, 5, 5, 5, 2);
    for (int k = 0; k < 32; k++) begin
      exp_c = (((k / 8) % 2) == 0) ? rgb(5, 5, 5) : rgb(0, 0, 0);
      checks++; if (a_rgb !== exp_c) begin errors++; $display("[TB] FAIL blink_rgb k=%0d: got %h expected %h", k, a_rgb, exp_c); end
      checks++; if ({a_set, a_busy} !== {(k % 8) == 0, 1'b1}) begin errors++; $display("[TB] FAIL blink_set k=%0d: set/busy got %b expected %b", k, {a_set, a_busy}, {(k % 8) == 0, 1'b1}); end
      @(negedge clk);
    end
  endtask

  task automatic test_preempt;
    int pulses, changed;
    repeat (7) @(negedge clk);
    checks++; if ({a_rgb, a_set} !== {rgb(5, 5, 5), 1'b0}) begin errors++; $display("[TB] FAIL preempt_pre: rgb/set got %h expected %h", {a_rgb, a_set}, {rgb(5, 5, 5), 1'b0}); end
    send_a(2'b01, 0, 31, 0, 3);
    checks++; if (a_rgb !== rgb(0, 31, 0)) begin errors++; $display("[TB] FAIL preempt_rgb: got %h expected %h", a_rgb, rgb(0, 31, 0)); end
    checks++; if ({a_set, a_busy} !== 2'b10) begin errors++; $display("[TB] FAIL preempt_load: set/busy got %b expected 10", {a_set, a_busy}); end
    pulses = 0; changed = 0;
    repeat (40) begin
      @(negedge clk);
      if (a_set) pulses++;
      if (a_rgb !== rgb(0, 31, 0) || a_busy !== 1'b0) changed++;
    end
    checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL preempt_no_blink: got %0d pulses expected 0", pulses); end
    checks++; if (changed != 0) begin errors++; $display("[TB] FAIL preempt_static: got %0d bad cycles expected 0", changed); end
  endtask

  task automatic test_period_zero;
    logic [3*W-1:0] exp_c;
    logic           exp_s;
    wait_phase(4, 1);
    send_a(2'b10, 7, 14, 21, 0);
    for (int k = 0; k < 18; k++) begin
      if (k < 2) begin
        exp_c = rgb(7, 14, 21);
        exp_s = (k == 0);
      end else begin
        exp_c = ((((k - 2) / 4) % 2) == 0) ? rgb(0, 0, 0) : rgb(7, 14, 21);
        exp_s = (((k - 2) % 4) == 0);
      end
      checks++; if ({a_rgb, a_set, a_busy} !== {exp_c, exp_s, 1'b1}) begin errors++; $display("[TB] FAIL period0 k=%0d: rgb/set/busy got %h expected %h", k, {a_rgb, a_set, a_busy}, {exp_c, exp_s, 1'b1}); end
      @(negedge clk);
    end
  endtask

  task automatic test_off;
    int pulses, changed;
    send_a(2'b00, 9, 9, 9, 5);
    checks++; if (a_rgb !== '0) begin errors++; $display("[TB] FAIL off_rgb: got %h expected 0", a_rgb); end
    checks++; if ({a_set, a_ready, a_busy} !== 3'b100) begin errors++; $display("[TB] FAIL off_load: set/ready/busy got %b expected 100", {a_set, a_ready, a_busy}); end
    pulses = 0; changed = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_set) pulses++;
      if (a_rgb !== '0) changed++;
    end
    checks++; if (pulses != 0 || changed != 0) begin errors++; $display("[TB] FAIL off_static: got %0d pulses %0d bad cycles expected 0 0", pulses, changed); end
  endtask

  task automatic test_fade;
    logic [3*W-1:0] exp_c;
    wait_phase(2, 1);
    send_b(2'b11, 3, 1, 0, 1);
    checks++; if (b_ready !== 1'b0) begin errors++; $display("[TB] FAIL fade_load_ready: got %b expected 0", b_ready); end
    for (int k = 0; k <= 16; k++) begin
      exp_c = fade_level(k / 2);
      checks++; if (b_rgb !== exp_c) begin errors++; $display("[TB] FAIL fade_rgb k=%0d: got %h expected %h", k, b_rgb, exp_c); end
      checks++; if ({b_set, b_busy} !== {(k % 2) == 0, 1'b1}) begin errors++; $display("[TB] FAIL fade_set k=%0d: set/busy got %b expected %b", k, {b_set, b_busy}, {(k % 2) == 0, 1'b1}); end
      if (k < 16) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_fade;
    int hold;
    // Pick a reset length that would leave a non-restarted prescaler on the opposite phase.
    hold = ((cyc % 2) == 1) ? 2 : 3;
    rst = 1'b1;
    #1;
    checks++; if (b_set !== 1'b0) begin errors++; $display("[TB] FAIL midreset_set_now: got %b expected 0", b_set); end
    @(negedge clk);
    checks++; if ({b_rgb, b_set, b_ready, b_busy} !== '0) begin errors++; $display("[TB] FAIL midreset_outputs: got %h expected 0", {b_rgb, b_set, b_ready, b_busy}); end
    repeat (hold - 1) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({b_rgb, b_set} !== {15'd0, 1'b1}) begin errors++; $display("[TB] FAIL midreset_init: rgb/set got %h expected %h", {b_rgb, b_set}, {15'd0, 1'b1}); end
    @(negedge clk);
    send_b(2'b11, 3, 1, 0, 1);
    checks++; if ({b_rgb, b_set} !== {15'd0, 1'b1}) begin errors++; $display("[TB] FAIL midreset_load: rgb/set got %h expected %h", {b_rgb, b_set}, {15'd0, 1'b1}); end
    @(negedge clk);
    checks++; if ({b_rgb, b_set} !== {15'd0, 1'b0}) begin errors++; $display("[TB] FAIL midreset_gap: rgb/set got %h expected %h", {b_rgb, b_set}, {15'd0, 1'b0}); end
    @(negedge clk);
    checks++; if ({b_rgb, b_set} !== {rgb(1, 1, 0), 1'b1}) begin errors++; $display("[TB] FAIL midreset_step: rgb/set got %h expected %h", {b_rgb, b_set}, {rgb(1, 1, 0), 1'b1}); end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    a_valid = 1'b0; a_mode = 2'b00; a_cr = '0; a_cg = '0; a_cb = '0; a_period = 8'd0;
    b_valid = 1'b0; b_mode = 2'b00; b_cr = '0; b_cg = '0; b_cb = '0; b_period = 8'd0;
    $display("[TB] starting rgb_led_seq bench");
    test_reset();
    test_solid();
    test_blink();
    test_preempt();
    test_period_zero();
    test_off();
    test_fade();
    test_reset_mid_fade();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
